// File: rtl/hwpf_stride_sched.sv
// rtl/hwpf_stride_sched.sv - round-robin scheduler sharing one HPDcache requester port among stride prefetch engines
// HPDCACHE_HWPF_SCHED_OUTREG_EN selects a one-entry output register stage; tid sits at REQ_TID_LSB / RSP_TID_LSB of the packed types.
module hwpf_stride_sched #(
  parameter int unsigned NUM_HW_PREFETCH = 4,
  parameter int unsigned TID_WIDTH       = 2,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned REQ_TID_LSB     = 0,
  parameter int unsigned RSP_TID_LSB     = 0,
  parameter type         hpdcache_req_t  = logic,
  parameter type         hpdcache_rsp_t  = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_HW_PREFETCH-1:0] engine_req_valid_i,
  output logic [NUM_HW_PREFETCH-1:0] engine_req_ready_o,
  input  hpdcache_req_t              engine_req_i [NUM_HW_PREFETCH],
  output logic [NUM_HW_PREFETCH-1:0] engine_rsp_valid_o,
  output hpdcache_rsp_t              engine_rsp_o,
  output logic                       hpdcache_req_valid_o,
  input  logic                       hpdcache_req_ready_i,
  output hpdcache_req_t              hpdcache_req_o,
  input  logic                       hpdcache_rsp_valid_i,
  input  hpdcache_rsp_t              hpdcache_rsp_i,
  output logic [7:0]                 outstanding_o,
  output logic                       tid_err_o,
  output logic                       busy_o
);
  localparam int unsigned N     = NUM_HW_PREFETCH;
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned REQ_W = $bits(hpdcache_req_t);
  localparam int unsigned RSP_W = $bits(hpdcache_rsp_t);
  localparam logic [7:0]  MAX_OUT = 8'(MAX_OUTSTANDING);

  // The request types are opaque; tid is overwritten by bit position.
  function automatic hpdcache_req_t tag_req(input hpdcache_req_t req, input logic [IDX_W-1:0] idx);
    logic [REQ_W+TID_WIDTH-1:0] ext;
    ext = {{TID_WIDTH{1'b0}}, req};
    ext[REQ_TID_LSB +: TID_WIDTH] = TID_WIDTH'(idx);
    return hpdcache_req_t'(REQ_W'(ext));
  endfunction

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]       outstanding_q, outstanding_d;
  logic             tid_err_q, tid_err_d;

  logic             rr_found;
  logic [IDX_W-1:0] rr_idx;
  logic             credit_ok;
  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;
  logic             eng_hs;
  logic             req_valid;
  hpdcache_req_t    req_data;
  logic             ds_hs;

  always_comb begin
    logic [IDX_W-1:0] cand;
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + k) % N);
      if (!rr_found && engine_req_valid_i[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

`ifdef HPDCACHE_HWPF_SCHED_OUTREG_EN
  logic          stage_valid_q, stage_valid_d;
  hpdcache_req_t stage_req_q, stage_req_d;
  logic          load_en;

  // An occupied stage already owns a credit even though it has not handshaken yet.
  always_comb begin
    credit_ok     = (9'(outstanding_q) + 9'(stage_valid_q)) < 9'(MAX_OUTSTANDING);
    load_en       = !stage_valid_q || hpdcache_req_ready_i;
    grant_any     = credit_ok && rr_found;
    grant_idx     = rr_idx;
    eng_hs        = grant_any && load_en;
    stage_valid_d = stage_valid_q;
    stage_req_d   = stage_req_q;
    if (load_en) begin
      stage_valid_d = grant_any;
      if (grant_any) begin
        stage_req_d = tag_req(engine_req_i[grant_idx], grant_idx);
      end
    end
    req_valid = stage_valid_q;
    req_data  = stage_req_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_valid_q <= 1'b0;
      stage_req_q   <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_req_q   <= stage_req_d;
    end
  end
`else
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  // A waiting request keeps its engine until the handshake, unless that engine withdraws.
  always_comb begin
    credit_ok = outstanding_q < MAX_OUT;
    grant_any = 1'b0;
    grant_idx = rr_idx;
    if (credit_ok) begin
      if (lock_q && engine_req_valid_i[lock_idx_q]) begin
        grant_any = 1'b1;
        grant_idx = lock_idx_q;
      end else if (rr_found) begin
        grant_any = 1'b1;
        grant_idx = rr_idx;
      end
    end
    eng_hs     = grant_any && hpdcache_req_ready_i;
    lock_d     = grant_any && !hpdcache_req_ready_i;
    lock_idx_d = grant_any ? grant_idx : lock_idx_q;
    req_valid  = grant_any;
    req_data   = tag_req(engine_req_i[grant_idx], grant_idx);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`endif

  logic [RSP_W+TID_WIDTH-1:0] rsp_ext;
  logic [TID_WIDTH-1:0]       rsp_tid;
  logic                       rsp_tid_ok;

  always_comb begin
    rsp_ext    = {{TID_WIDTH{1'b0}}, hpdcache_rsp_i};
    rsp_tid    = TID_WIDTH'(rsp_ext >> RSP_TID_LSB);
    rsp_tid_ok = 32'(rsp_tid) < N;
    ds_hs      = req_valid && hpdcache_req_ready_i;
  end

  // Increment and decrement cancel; a lone response saturates at zero.
  always_comb begin
    outstanding_d = outstanding_q;
    if (ds_hs && !hpdcache_rsp_valid_i) begin
      outstanding_d = outstanding_q + 8'd1;
    end else if (!ds_hs && hpdcache_rsp_valid_i && (outstanding_q != 8'd0)) begin
      outstanding_d = outstanding_q - 8'd1;
    end
    tid_err_d = tid_err_q || (hpdcache_rsp_valid_i && !rsp_tid_ok);
    rr_ptr_d  = eng_hs ? IDX_W'((32'(grant_idx) + 1) % N) : rr_ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
      tid_err_q     <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
      tid_err_q     <= tid_err_d;
    end
  end

  // Combinational outputs are forced low while reset is held.
  always_comb begin
    engine_req_ready_o = '0;
    engine_rsp_valid_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      engine_req_ready_o[i] = rst_ni && eng_hs && (32'(grant_idx) == i);
      engine_rsp_valid_o[i] = rst_ni && hpdcache_rsp_valid_i && (32'(rsp_tid) == i);
    end
    engine_rsp_o         = rst_ni ? hpdcache_rsp_i : '0;
    hpdcache_req_valid_o = rst_ni && req_valid;
    hpdcache_req_o       = rst_ni ? req_data : '0;
    outstanding_o        = outstanding_q;
    tid_err_o            = tid_err_q;
    busy_o               = rst_ni && ((|engine_req_valid_i) || req_valid || (outstanding_q != 8'd0));
  end

endmodule
